// File: rtl/sram_is61wv25616_model_if.sv
// Control and address pins of an IS61WV25616-style asynchronous SRAM.
// The DQ bus is a resolved net and stays a module-level inout port.
interface sram_is61wv25616_model_if;
    logic [17:0] SRAM_ADDR;
    logic        SRAM_CE_N;
    logic        SRAM_WE_N;
    logic        SRAM_OE_N;
    logic        SRAM_LB_N;
    logic        SRAM_UB_N;

    modport master (
        output SRAM_ADDR, SRAM_CE_N, SRAM_WE_N, SRAM_OE_N, SRAM_LB_N, SRAM_UB_N
    );

    modport slave (
        input  SRAM_ADDR, SRAM_CE_N, SRAM_WE_N, SRAM_OE_N, SRAM_LB_N, SRAM_UB_N
    );
endinterface

// File: rtl/sram_is61wv25616_model.sv
// Clocked IS61WV25616-style SRAM responder built from on-chip memory.
// Define SRAM_MODEL_CLEAR_EN to zero the array with a sweep after every reset.
module sram_is61wv25616_model #(
    parameter int unsigned ADDR_W = 12,
    parameter int unsigned CNT_W  = 16
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    sram_is61wv25616_model_if.slave bus,
    inout  wire  [15:0]             SRAM_DQ,
    output logic                    o_busy,
    output logic                    o_err,
    output logic [CNT_W-1:0]        o_wr_cnt,
    output logic [CNT_W-1:0]        o_rd_cnt
);
    localparam int unsigned DEPTH = 1 << ADDR_W;

    logic [15:0]       mem [DEPTH];
    logic [ADDR_W-1:0] a;
    logic              ready;
    logic              clr_we;
    logic [ADDR_W-1:0] clr_ptr;

`ifdef SRAM_MODEL_CLEAR_EN
    typedef enum logic {CLEAR, READY} state_t;

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W-1:0] ptr;
    logic [ADDR_W-1:0] ptr_nxt;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state <= CLEAR;
            ptr   <= '0;
        end else begin
            state <= state_nxt;
            ptr   <= ptr_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        if (state == CLEAR) begin
            ptr_nxt = ptr + 1'b1;
            if (ptr == '1) state_nxt = READY;
        end
    end

    assign ready   = (state == READY);
    assign clr_we  = (state == CLEAR);
    assign clr_ptr = ptr;
    assign o_busy  = (state == CLEAR);
`else
    // No sweep: accesses are accepted whenever reset is released.
    assign ready   = ~i_rst;
    assign clr_we  = 1'b0;
    assign clr_ptr = '0;
    assign o_busy  = 1'b0;
`endif

    logic acc, wr, rd, wr_lo, wr_hi, rd_lo, rd_hi, conflict;

    assign a        = bus.SRAM_ADDR[ADDR_W-1:0];
    assign acc      = ready & ~bus.SRAM_CE_N;
    assign wr       = acc & ~bus.SRAM_WE_N;
    assign rd       = acc & bus.SRAM_WE_N & ~bus.SRAM_OE_N;
    assign wr_lo    = wr & ~bus.SRAM_LB_N;
    assign wr_hi    = wr & ~bus.SRAM_UB_N;
    assign rd_lo    = rd & ~bus.SRAM_LB_N;
    assign rd_hi    = rd & ~bus.SRAM_UB_N;
    assign conflict = wr & ~bus.SRAM_OE_N;

    assign SRAM_DQ[7:0]  = rd_lo ? mem[a][7:0]  : 8'hzz;
    assign SRAM_DQ[15:8] = rd_hi ? mem[a][15:8] : 8'hzz;

    always_ff @(posedge i_clk) begin
        if (clr_we) mem[clr_ptr] <= '0;
        if (wr_lo)  mem[a][7:0]  <= SRAM_DQ[7:0];
        if (wr_hi)  mem[a][15:8] <= SRAM_DQ[15:8];
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_err    <= 1'b0;
            o_wr_cnt <= '0;
            o_rd_cnt <= '0;
        end else begin
            if (conflict) o_err <= 1'b1;
            if ((wr_lo | wr_hi) && (o_wr_cnt != '1)) o_wr_cnt <= o_wr_cnt + 1'b1;
            if ((rd_lo | rd_hi) && (o_rd_cnt != '1)) o_rd_cnt <= o_rd_cnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_sram_is61wv25616_model.sv
// Directed self-checking bench for sram_is61wv25616_model (ADDR_W=4, CNT_W=16).
// A pull-up on DQ makes an undriven lane read as 8'hFF.
module tb_sram_is61wv25616_model;
    localparam int unsigned ADDR_W = 4;
    localparam int unsigned CNT_W  = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    sram_is61wv25616_model_if bus ();

    wire  [15:0] dq;
    logic [15:0] drv    = '0;
    logic        drv_en = 1'b0;
    assign dq = drv_en ? drv : 16'hzzzz;
    pullup pu_dq (dq);

    logic             busy, err;
    logic [CNT_W-1:0] wr_cnt, rd_cnt;

    sram_is61wv25616_model #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
        .i_clk    (clk),
        .i_rst    (rst),
        .bus      (bus),
        .SRAM_DQ  (dq),
        .o_busy   (busy),
        .o_err    (err),
        .o_wr_cnt (wr_cnt),
        .o_rd_cnt (rd_cnt)
    );

    int unsigned      n_cmp = 0;
    int unsigned      n_bad = 0;
    logic [CNT_W-1:0] exp_wr = '0;
    logic [CNT_W-1:0] exp_rd = '0;
    logic [15:0]      got;

`ifdef SRAM_MODEL_CLEAR_EN
    localparam logic BUSY_RST = 1'b1;
`else
    localparam logic BUSY_RST = 1'b0;
`endif

    task automatic set_idle();
        bus.SRAM_ADDR = '0;
        bus.SRAM_CE_N = 1'b1;
        bus.SRAM_WE_N = 1'b1;
        bus.SRAM_OE_N = 1'b1;
        bus.SRAM_LB_N = 1'b0;
        bus.SRAM_UB_N = 1'b0;
        drv_en        = 1'b0;
        drv           = '0;
    endtask

    task automatic do_write(input logic [17:0] addr, input logic [15:0] data,
                            input logic lb, input logic ub);
        @(negedge clk);
        bus.SRAM_ADDR = addr;
        bus.SRAM_CE_N = 1'b0;
        bus.SRAM_WE_N = 1'b0;
        bus.SRAM_OE_N = 1'b1;
        bus.SRAM_LB_N = lb;
        bus.SRAM_UB_N = ub;
        drv           = data;
        drv_en        = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic do_read(input logic [17:0] addr, input logic lb, input logic ub,
                           output logic [15:0] q);
        @(negedge clk);
        bus.SRAM_ADDR = addr;
        bus.SRAM_CE_N = 1'b0;
        bus.SRAM_WE_N = 1'b1;
        bus.SRAM_OE_N = 1'b0;
        bus.SRAM_LB_N = lb;
        bus.SRAM_UB_N = ub;
        drv_en        = 1'b0;
        #1 q = dq;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        set_idle();
        bus.SRAM_CE_N = 1'b0;
        bus.SRAM_OE_N = 1'b0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++; if (busy !== BUSY_RST) begin n_bad++; $display("FAIL reset_busy got %b want %b", busy, BUSY_RST); end
        n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL reset_err got %b want 0", err); end
        n_cmp++; if (wr_cnt !== '0) begin n_bad++; $display("FAIL reset_wr_cnt got %h want 0", wr_cnt); end
        n_cmp++; if (rd_cnt !== '0) begin n_bad++; $display("FAIL reset_rd_cnt got %h want 0", rd_cnt); end
        n_cmp++; if (dq !== 16'hFFFF) begin n_bad++; $display("FAIL reset_dq_z got %h want FFFF(z)", dq); end
    endtask

    task automatic test_clear();
        @(negedge clk);
        set_idle();
        rst = 1'b0;
`ifdef SRAM_MODEL_CLEAR_EN
        // Writes attempted during the sweep must be ignored.
        bus.SRAM_ADDR = 18'h0;
        bus.SRAM_CE_N = 1'b0;
        bus.SRAM_WE_N = 1'b0;
        drv           = 16'h1234;
        drv_en        = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            @(posedge clk);
            #1;
            n_cmp++;
            if (busy !== (i < 16)) begin
                n_bad++; $display("FAIL clear_busy cycle %0d got %b want %b", i, busy, (i < 16));
            end
        end
        @(negedge clk);
        set_idle();
        n_cmp++; if (wr_cnt !== '0) begin n_bad++; $display("FAIL clear_wr_cnt got %h want 0", wr_cnt); end
        for (int i = 0; i < 16; i++) begin
            do_read(18'(i), 1'b0, 1'b0, got);
            exp_rd++;
            n_cmp++; if (got !== 16'h0000) begin n_bad++; $display("FAIL clear_read addr %0d got %h want 0000", i, got); end
        end
        n_cmp++; if (rd_cnt !== exp_rd) begin n_bad++; $display("FAIL clear_rd_cnt got %h want %h", rd_cnt, exp_rd); end
`else
        repeat (2) @(posedge clk);
        #1;
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL noclear_busy got %b want 0", busy); end
`endif
    endtask

    task automatic test_byte_lanes();
        do_write(18'd3, 16'hA5C3, 1'b0, 1'b0);
        do_write(18'd3, 16'hFF11, 1'b1, 1'b0);
        exp_wr += 2;
        do_read(18'd3, 1'b0, 1'b0, got);
        exp_rd++;
        n_cmp++; if (got !== 16'hFFC3) begin n_bad++; $display("FAIL lanes_merge got %h want FFC3", got); end
        n_cmp++; if (wr_cnt !== exp_wr) begin n_bad++; $display("FAIL lanes_wr_cnt got %h want %h", wr_cnt, exp_wr); end
        do_write(18'd4, 16'h0011, 1'b0, 1'b0);
        exp_wr++;
        do_read(18'd4, 1'b0, 1'b1, got);
        exp_rd++;
        n_cmp++; if (got !== 16'hFF11) begin n_bad++; $display("FAIL lanes_rd_lo got %h want FF11", got); end
        do_read(18'd4, 1'b1, 1'b0, got);
        exp_rd++;
        n_cmp++; if (got !== 16'h00FF) begin n_bad++; $display("FAIL lanes_rd_hi got %h want 00FF", got); end
        n_cmp++; if (rd_cnt !== exp_rd) begin n_bad++; $display("FAIL lanes_rd_cnt got %h want %h", rd_cnt, exp_rd); end
    endtask

    task automatic test_back_to_back();
        do_write(18'd8, 16'h5678, 1'b0, 1'b0);
        do_write(18'd9, 16'h1234, 1'b0, 1'b0);
        exp_wr += 2;
        do_read(18'd8, 1'b0, 1'b0, got);
        n_cmp++; if (got !== 16'h5678) begin n_bad++; $display("FAIL b2b_rd8 got %h want 5678", got); end
        do_read(18'd9, 1'b0, 1'b0, got);
        n_cmp++; if (got !== 16'h1234) begin n_bad++; $display("FAIL b2b_rd9 got %h want 1234", got); end
        exp_rd += 2;
        n_cmp++; if (rd_cnt !== exp_rd) begin n_bad++; $display("FAIL b2b_rd_cnt got %h want %h", rd_cnt, exp_rd); end
        n_cmp++; if (wr_cnt !== exp_wr) begin n_bad++; $display("FAIL b2b_wr_cnt got %h want %h", wr_cnt, exp_wr); end
    endtask

    task automatic test_conflict();
        n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL conflict_pre_err got %b want 0", err); end
        @(negedge clk);
        bus.SRAM_ADDR = 18'd2;
        bus.SRAM_CE_N = 1'b0;
        bus.SRAM_WE_N = 1'b0;
        bus.SRAM_OE_N = 1'b0;
        bus.SRAM_LB_N = 1'b0;
        bus.SRAM_UB_N = 1'b0;
        drv           = 16'hBEEF;
        drv_en        = 1'b1;
        #1;
        n_cmp++; if (dq !== 16'hBEEF) begin n_bad++; $display("FAIL conflict_dq got %h want BEEF", dq); end
        @(posedge clk);
        #1;
        exp_wr++;
        n_cmp++; if (err !== 1'b1) begin n_bad++; $display("FAIL conflict_err got %b want 1", err); end
        n_cmp++; if (wr_cnt !== exp_wr) begin n_bad++; $display("FAIL conflict_wr_cnt got %h want %h", wr_cnt, exp_wr); end
        n_cmp++; if (rd_cnt !== exp_rd) begin n_bad++; $display("FAIL conflict_rd_cnt got %h want %h", rd_cnt, exp_rd); end
        @(negedge clk);
        set_idle();
        repeat (3) @(posedge clk);
        #1;
        n_cmp++; if (err !== 1'b1) begin n_bad++; $display("FAIL conflict_sticky got %b want 1", err); end
        do_read(18'd2, 1'b0, 1'b0, got);
        exp_rd++;
        n_cmp++; if (got !== 16'hBEEF) begin n_bad++; $display("FAIL conflict_readback got %h want BEEF", got); end
    endtask

    task automatic test_alias_idle();
        do_write(18'h10005, 16'h0C0D, 1'b0, 1'b0);
        exp_wr++;
        do_read(18'd5, 1'b0, 1'b0, got);
        exp_rd++;
        n_cmp++; if (got !== 16'h0C0D) begin n_bad++; $display("FAIL alias_read got %h want 0C0D", got); end
        // Deselected read.
        @(negedge clk);
        set_idle();
        bus.SRAM_ADDR = 18'd5;
        bus.SRAM_OE_N = 1'b0;
        #1;
        n_cmp++; if (dq !== 16'hFFFF) begin n_bad++; $display("FAIL idle_ce_dq got %h want FFFF(z)", dq); end
        @(posedge clk);
        #1;
        n_cmp++; if (rd_cnt !== exp_rd) begin n_bad++; $display("FAIL idle_ce_rd_cnt got %h want %h", rd_cnt, exp_rd); end
        // Deselected write.
        @(negedge clk);
        bus.SRAM_OE_N = 1'b1;
        bus.SRAM_WE_N = 1'b0;
        drv           = 16'h7777;
        drv_en        = 1'b1;
        @(posedge clk);
        #1;
        n_cmp++; if (wr_cnt !== exp_wr) begin n_bad++; $display("FAIL idle_ce_wr_cnt got %h want %h", wr_cnt, exp_wr); end
        // Selected, both lanes disabled: read then write.
        @(negedge clk);
        set_idle();
        bus.SRAM_ADDR = 18'd5;
        bus.SRAM_CE_N = 1'b0;
        bus.SRAM_OE_N = 1'b0;
        bus.SRAM_LB_N = 1'b1;
        bus.SRAM_UB_N = 1'b1;
        #1;
        n_cmp++; if (dq !== 16'hFFFF) begin n_bad++; $display("FAIL nolane_dq got %h want FFFF(z)", dq); end
        @(posedge clk);
        #1;
        n_cmp++; if (rd_cnt !== exp_rd) begin n_bad++; $display("FAIL nolane_rd_cnt got %h want %h", rd_cnt, exp_rd); end
        @(negedge clk);
        bus.SRAM_OE_N = 1'b1;
        bus.SRAM_WE_N = 1'b0;
        drv           = 16'h7777;
        drv_en        = 1'b1;
        @(posedge clk);
        #1;
        n_cmp++; if (wr_cnt !== exp_wr) begin n_bad++; $display("FAIL nolane_wr_cnt got %h want %h", wr_cnt, exp_wr); end
        do_read(18'd5, 1'b0, 1'b0, got);
        exp_rd++;
        n_cmp++; if (got !== 16'h0C0D) begin n_bad++; $display("FAIL idle_no_write got %h want 0C0D", got); end
        n_cmp++; if (rd_cnt !== exp_rd) begin n_bad++; $display("FAIL idle_rd_cnt got %h want %h", rd_cnt, exp_rd); end
    endtask

    task automatic test_reset_mid();
`ifdef SRAM_MODEL_CLEAR_EN
        @(negedge clk);
        set_idle();
        rst = 1'b1;
        #1;
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL rst_async_busy got %b want 1", busy); end
        n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL rst_async_err got %b want 0", err); end
        n_cmp++; if (rd_cnt !== '0) begin n_bad++; $display("FAIL rst_async_rd_cnt got %h want 0", rd_cnt); end
        n_cmp++; if (wr_cnt !== '0) begin n_bad++; $display("FAIL rst_async_wr_cnt got %h want 0", wr_cnt); end
        exp_wr = '0;
        exp_rd = '0;
        @(negedge clk);
        rst = 1'b0;
        repeat (7) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL rst_mid_busy got %b want 1", busy); end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 1; i <= 16; i++) begin
            @(posedge clk);
            #1;
            n_cmp++;
            if (busy !== (i < 16)) begin
                n_bad++; $display("FAIL rst_mid_sweep cycle %0d got %b want %b", i, busy, (i < 16));
            end
        end
        do_read(18'd2, 1'b0, 1'b0, got);
        exp_rd++;
        n_cmp++; if (got !== 16'h0000) begin n_bad++; $display("FAIL rst_mid_cleared got %h want 0000", got); end
`else
        do_write(18'd6, 16'h1111, 1'b0, 1'b0);
        // Reset raised while a write is presented: that write must be lost.
        @(negedge clk);
        bus.SRAM_ADDR = 18'd6;
        drv           = 16'h2222;
        rst           = 1'b1;
        #1;
        n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL rst_async_err got %b want 0", err); end
        n_cmp++; if (wr_cnt !== '0) begin n_bad++; $display("FAIL rst_async_wr_cnt got %h want 0", wr_cnt); end
        n_cmp++; if (rd_cnt !== '0) begin n_bad++; $display("FAIL rst_async_rd_cnt got %h want 0", rd_cnt); end
        @(posedge clk);
        @(negedge clk);
        set_idle();
        rst    = 1'b0;
        exp_wr = '0;
        exp_rd = '0;
        do_read(18'd6, 1'b0, 1'b0, got);
        exp_rd++;
        n_cmp++; if (got !== 16'h1111) begin n_bad++; $display("FAIL rst_mid_discard got %h want 1111", got); end
`endif
        n_cmp++; if (rd_cnt !== exp_rd) begin n_bad++; $display("FAIL rst_mid_rd_cnt got %h want %h", rd_cnt, exp_rd); end
        n_cmp++; if (wr_cnt !== exp_wr) begin n_bad++; $display("FAIL rst_mid_wr_cnt got %h want %h", wr_cnt, exp_wr); end
    endtask

    task automatic test_saturation();
        int n;
        n = 65534 - int'(exp_rd);
        @(negedge clk);
        set_idle();
        bus.SRAM_ADDR = 18'd5;
        bus.SRAM_CE_N = 1'b0;
        bus.SRAM_OE_N = 1'b0;
        repeat (n) @(posedge clk);
        #1;
        n_cmp++; if (rd_cnt !== 16'hFFFE) begin n_bad++; $display("FAIL sat_pre got %h want FFFE", rd_cnt); end
        @(posedge clk);
        #1;
        n_cmp++; if (rd_cnt !== 16'hFFFF) begin n_bad++; $display("FAIL sat_reach got %h want FFFF", rd_cnt); end
        repeat (2) @(posedge clk);
        #1;
        n_cmp++; if (rd_cnt !== 16'hFFFF) begin n_bad++; $display("FAIL sat_hold got %h want FFFF", rd_cnt); end
        n_cmp++; if (wr_cnt !== exp_wr) begin n_bad++; $display("FAIL sat_wr_cnt got %h want %h", wr_cnt, exp_wr); end
        @(negedge clk);
        set_idle();
    endtask

    initial begin
        test_reset();
        test_clear();
        test_byte_lanes();
        test_back_to_back();
        test_conflict();
        test_alias_idle();
        test_reset_mid();
        test_saturation();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #1500000;
        $display("FAIL watchdog expired before end of tests (compared %0d)", n_cmp);
        $fatal(1, "timeout");
    end
endmodule
